gate_truth_checker: RTL and testbench

Self-checking truth-table exerciser for 2-input combinational gates. On a start pulse it drives all four input combinations onto a gate under test, samples the gate output after a programmable settle time, and compares each sample against a parameterised expected truth table. It reports per-vector failures, an error count and a pass flag. It is the synthesizable response-checking counterpart to the team's gate stimulus benches and is used for on-board or in-system gate checks.

---
 rtl/gate_truth_checker.sv | 167 ++++++++++++++++
 tb/tb_gate_truth_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//
// Truth-table exerciser for a 2-input combinational gate. A start pulse walks
// the four input combinations {a_o,b_o} = 00, 01, 10, 11 onto the gate under
// test. Each vector is held for SETTLE cycles. On the last cycle of each vector
// the gate output y_i is compared against EXPECT[{a_o,b_o}]. Once the run
// completes, the module reports a per-vector fail mask, a mismatch count and a
// pass flag. These results stay valid until the next accepted start.
//
// Parameters:
//   EXPECT    expected truth table; bit k is the expected y for {a,b}=k
//             (default NAND)
//   SETTLE    cycles each vector is held before y_i is sampled (1..255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     run request; only accepted while idle
//   y_i       output of the gate under test
//   a_o, b_o  registered gate inputs
//   busy      high while a run is in progress
//   done      one-cycle pulse when the results become valid
//   pass      last completed run had no mismatches
//   err_cnt   mismatch count of the last or current run (0..4)
//   fail_mask bit k set when vector k mismatched
//   vec_idx   index of the vector currently driven

module gate_truth_checker #(
    parameter logic [3:0]  EXPECT = 4'b0111,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The settle counter ends at this value. The last cycle of each vector is
    // the sample edge.
    localparam logic [7:0] SAMPLE_AT = 8'(SETTLE - 1);

    state_t     state, state_next;
    logic [7:0] settle_cnt, settle_cnt_next;
    logic [1:0] vec_idx_next;
    logic [2:0] err_cnt_next, err_cnt_upd;
    logic [3:0] fail_mask_next, fail_mask_upd;
    logic [3:0] expect_tbl;
    logic       pass_next, busy_next, done_next, a_next, b_next;
    logic       mismatch;

    assign expect_tbl = EXPECT;

    // Next-state and output logic. Every output is registered, so this block
    // only computes the values they take at the coming edge. By default each
    // value holds its current setting. done is the exception: it is a pulse.
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        vec_idx_next    = vec_idx;
        err_cnt_next    = err_cnt;
        fail_mask_next  = fail_mask;
        pass_next       = pass;
        busy_next       = busy;
        done_next       = 1'b0;
        a_next          = a_o;
        b_next          = b_o;

        // This is the result of comparing the current vector. It is used
        // only on the sample edge.
        mismatch      = (y_i != expect_tbl[vec_idx]);
        err_cnt_upd   = err_cnt + {2'b00, mismatch};
        fail_mask_upd = fail_mask | (mismatch ? (4'b0001 << vec_idx) : 4'b0000);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next      = RUN;
                    settle_cnt_next = 8'd0;
                    vec_idx_next    = 2'd0;
                    err_cnt_next    = 3'd0;
                    fail_mask_next  = 4'd0;
                    pass_next       = 1'b0;
                    busy_next       = 1'b1;
                    a_next          = 1'b0;
                    b_next          = 1'b0;
                end
            end

            RUN: begin
                if (settle_cnt == SAMPLE_AT) begin
                    err_cnt_next   = err_cnt_upd;
                    fail_mask_next = fail_mask_upd;
                    if (vec_idx != 2'd3) begin
                        vec_idx_next     = vec_idx + 2'd1;
                        {a_next, b_next} = vec_idx + 2'd1;
                        settle_cnt_next  = 8'd0;
                    end else begin
                        // The vector-3 mismatch must be included in pass.
                        // Pass is therefore computed from the updated count.
                        state_next      = DONE;
                        vec_idx_next    = 2'd0;
                        settle_cnt_next = 8'd0;
                        a_next          = 1'b0;
                        b_next          = 1'b0;
                        busy_next       = 1'b0;
                        done_next       = 1'b1;
                        pass_next       = (err_cnt_upd == 3'd0);
                    end
                end else begin
                    settle_cnt_next = settle_cnt + 8'd1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Reset takes priority over everything,
    // including a start in the same cycle. A run that is aborted by reset
    // never produces a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            vec_idx    <= 2'd0;
            err_cnt    <= 3'd0;
            fail_mask  <= 4'd0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            vec_idx    <= vec_idx_next;
            err_cnt    <= err_cnt_next;
            fail_mask  <= fail_mask_next;
            pass       <= pass_next;
            busy       <= busy_next;
            done       <= done_next;
            a_o        <= a_next;
            b_o        <= b_next;
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker
//
// This bench drives two checkers: one with SETTLE=1 and one with SETTLE=3,
// both expecting NAND. The SETTLE=1 instance is attached to a selectable
// gate: NAND, AND, or a constant 1. The SETTLE=3 instance's y_i is driven
// directly from the stimulus. A run-level model predicts every output from
// elapsed time since the start edge. Directed runs add hand-computed checks
// on results and latency.

module tb_gate_truth_checker;

    logic       clk;
    logic       rst;
    logic       start1, start3;
    logic       y1, y3;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] mask1;
    logic [1:0] vec1;
    logic       a3, b3, busy3, done3, pass3;
    logic [2:0] err3;
    logic [3:0] mask3;
    logic [1:0] vec3;
    int         gateSel;

    int compared   = 0;
    int mismatched = 0;
    int cycleCnt   = 0;
    int doneCount1 = 0;
    int doneCount3 = 0;

    gate_truth_checker #(.EXPECT(4'b0111), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_i(y1),
        .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_mask(mask1), .vec_idx(vec1)
    );

    gate_truth_checker #(.EXPECT(4'b0111), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .y_i(y3),
        .a_o(a3), .b_o(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .fail_mask(mask3), .vec_idx(vec3)
    );

    // The gate under test for the SETTLE=1 checker.
    assign y1 = (gateSel == 0) ? ~(a1 & b1) :
                (gateSel == 1) ?  (a1 & b1) : 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // The model tracks elapsed cycles since the start edge. The vector index
    // is t/settle. A sample edge occurs whenever t reaches a multiple of
    // settle.
    typedef struct {
        bit       running;
        bit       inDone;
        int       t;
        bit [2:0] err;
        bit [3:0] mask;
        bit       pass;
    } model_t;

    model_t m1 = '{default: 0};
    model_t m3 = '{default: 0};

    function automatic model_t stepModel(model_t m, bit r, bit s, bit y,
                                         int settle, bit [3:0] expTbl);
        model_t n = m;
        int k;
        if (r) begin
            n = '{default: 0};
        end else if (m.inDone) begin
            n.inDone = 0;
        end else if (m.running) begin
            n.t = m.t + 1;
            if (n.t % settle == 0) begin
                k = n.t / settle - 1;
                if (y != expTbl[k]) begin
                    n.mask[k] = 1'b1;
                    n.err     = n.err + 3'd1;
                end
                if (k == 3) begin
                    n.running = 0;
                    n.inDone  = 1;
                    n.pass    = (n.err == 0);
                    n.t       = 0;
                end
            end
        end else if (s) begin
            n.running = 1;
            n.t       = 0;
            n.err     = 0;
            n.mask    = 0;
            n.pass    = 0;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, expv, cycleCnt);
        end
    endtask

    task automatic compareDut(input string tag, input model_t m, input int settle,
                              input logic a, input logic b, input logic bsy,
                              input logic dn, input logic ps, input logic [2:0] e,
                              input logic [3:0] mk, input logic [1:0] v);
        logic [1:0] expVec;
        expVec = m.running ? 2'(m.t / settle) : 2'd0;
        checkOutput({tag, ".busy"}, {7'd0, bsy}, {7'd0, m.running});
        checkOutput({tag, ".done"}, {7'd0, dn}, {7'd0, m.inDone});
        checkOutput({tag, ".ab"}, {6'd0, a, b}, {6'd0, expVec});
        checkOutput({tag, ".pass"}, {7'd0, ps}, {7'd0, m.pass});
        checkOutput({tag, ".err_cnt"}, {5'd0, e}, {5'd0, m.err});
        checkOutput({tag, ".fail_mask"}, {4'd0, mk}, {4'd0, m.mask});
        if (m.running)
            checkOutput({tag, ".vec_idx"}, {6'd0, v}, {6'd0, expVec});
    endtask

    // The compare process runs on every falling edge. It checks the outputs
    // of both instances against the model state produced by the previous
    // rising edge. Then it advances the model using the inputs that the next
    // rising edge will see. Inputs change only just after a rising edge.
    always @(negedge clk) begin
        compareDut("dut1", m1, 1, a1, b1, busy1, done1, pass1, err1, mask1, vec1);
        compareDut("dut3", m3, 3, a3, b3, busy3, done3, pass3, err3, mask3, vec3);
        if (done1 === 1'b1) doneCount1++;
        if (done3 === 1'b1) doneCount3++;
        m1 = stepModel(m1, rst, start1, y1, 1, 4'b0111);
        m3 = stepModel(m3, rst, start3, y3, 3, 4'b0111);
    end

    // Presents one set of inputs and lets exactly one rising edge consume it.
    task automatic applyStimulus(input bit r, input bit s1, input bit s3);
        rst    = r;
        start1 = s1;
        start3 = s3;
        @(posedge clk);
        #1;
    endtask

    // Waits, with a cycle budget, for the falling edge inside the done cycle.
    // It returns the number of the rising edge that raised done.
    task automatic waitDone(input bit which, output int doneEdge);
        bit found = 0;
        doneEdge = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if ((which ? done3 : done1) === 1'b1) begin
                found    = 1;
                doneEdge = cycleCnt;
            end
        end
        if (!found) checkOutput(which ? "dut3.done_timeout" : "dut1.done_timeout", 8'd0, 8'd1);
    endtask

    int e0, dEdge, dc;

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; y3 = 1'b0; gateSel = 0;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("reset.busy", {7'd0, busy1}, 8'd0);
        checkOutput("reset.err_cnt", {5'd0, err1}, 8'd0);

        // A NAND run passes, with done 4 cycles after the start edge.
        $display("[TB] NAND run, SETTLE=1");
        gateSel = 0;
        applyStimulus(0, 1, 0);
        e0 = cycleCnt;
        start1 = 1'b0;
        waitDone(0, dEdge);
        checkOutput("nand.latency", 8'(dEdge - e0), 8'd4);
        checkOutput("nand.pass", {7'd0, pass1}, 8'd1);
        checkOutput("nand.err_cnt", {5'd0, err1}, 8'd0);
        checkOutput("nand.fail_mask", {4'd0, mask1}, 8'h0);
        applyStimulus(0, 0, 0);

        // An AND gate mismatches the NAND table on every vector.
        $display("[TB] AND run");
        gateSel = 1;
        applyStimulus(0, 1, 0);
        start1 = 1'b0;
        waitDone(0, dEdge);
        checkOutput("and.err_cnt", {5'd0, err1}, 8'd4);
        checkOutput("and.fail_mask", {4'd0, mask1}, 8'hf);
        checkOutput("and.pass", {7'd0, pass1}, 8'd0);
        applyStimulus(0, 0, 0);

        // A gate stuck at 1 fails only vector 3. The results then hold
        // through the idle period.
        $display("[TB] stuck-at-1 run");
        gateSel = 2;
        applyStimulus(0, 1, 0);
        start1 = 1'b0;
        waitDone(0, dEdge);
        checkOutput("one.fail_mask", {4'd0, mask1}, 8'h8);
        checkOutput("one.err_cnt", {5'd0, err1}, 8'd1);
        checkOutput("one.pass", {7'd0, pass1}, 8'd0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
        checkOutput("one.hold_mask", {4'd0, mask1}, 8'h8);
        checkOutput("one.hold_err", {5'd0, err1}, 8'd1);
        gateSel = 0;
        applyStimulus(0, 1, 0);
        start1 = 1'b0;
        checkOutput("restart.err_cnt", {5'd0, err1}, 8'd0);
        checkOutput("restart.fail_mask", {4'd0, mask1}, 8'h0);
        checkOutput("restart.busy", {7'd0, busy1}, 8'd1);
        waitDone(0, dEdge);
        applyStimulus(0, 0, 0);

        // With SETTLE=3, y3 is wrong for the first two cycles of each vector
        // and correct on the sample cycle.
        $display("[TB] SETTLE=3 run");
        applyStimulus(0, 0, 1);
        e0 = cycleCnt;
        start3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                y3 = (c < 2) ? (k[1] & k[0]) : ~(k[1] & k[0]);
                @(posedge clk);
                #1;
            end
        end
        waitDone(1, dEdge);
        checkOutput("settle3.latency", 8'(dEdge - e0), 8'd12);
        checkOutput("settle3.pass", {7'd0, pass3}, 8'd1);
        checkOutput("settle3.err_cnt", {5'd0, err3}, 8'd0);
        applyStimulus(0, 0, 0);

        // A start during RUN and a start during DONE are both ignored.
        $display("[TB] start during RUN and DONE");
        dc = doneCount1;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
        checkOutput("ignore.done_pulses", 8'(doneCount1 - dc), 8'd1);
        checkOutput("ignore.busy", {7'd0, busy1}, 8'd0);
        applyStimulus(0, 1, 0);
        start1 = 1'b0;
        checkOutput("ignore.next_accepted", {7'd0, busy1}, 8'd1);
        waitDone(0, dEdge);
        checkOutput("ignore.next_pass", {7'd0, pass1}, 8'd1);
        applyStimulus(0, 0, 0);

        // A reset in mid-run with a failing gate aborts the run. No done
        // pulse follows.
        $display("[TB] reset during run");
        gateSel = 1;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("abort.busy", {7'd0, busy1}, 8'd0);
        checkOutput("abort.ab", {6'd0, a1, b1}, 8'd0);
        checkOutput("abort.err_cnt", {5'd0, err1}, 8'd0);
        checkOutput("abort.fail_mask", {4'd0, mask1}, 8'h0);
        checkOutput("abort.pass", {7'd0, pass1}, 8'd0);
        checkOutput("abort.vec_idx", {6'd0, vec1}, 8'd0);
        dc = doneCount1;
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0);
        checkOutput("abort.no_done", 8'(doneCount1 - dc), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
